// File: rtl/cfu_cmd_master_if.sv
// CFU command/response bus between an initiator (master) and a Cfu responder (slave).
interface cfu_cmd_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_payload_outputs_0;

  modport master (
    output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_payload_outputs_0
  );

  modport slave (
    input  cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1, rsp_ready,
    output cmd_ready, rsp_valid, rsp_payload_outputs_0
  );
endinterface

// File: rtl/cfu_cmd_master.sv
// CFU initiator: issues one upstream request at a time to a Cfu responder, optionally
// re-issuing it with a fixed idle gap until the response is nonzero or a retry limit is hit.
module cfu_cmd_master #(
  parameter int POLL_GAP  = 4,
  parameter int POLL_MAX  = 1024,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [9:0]           req_function_id,
  input  logic [31:0]          req_inputs_0,
  input  logic [31:0]          req_inputs_1,
  input  logic                 req_poll,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [31:0]          res_data,
  output logic                 res_timeout,
  cfu_cmd_master_if.master     cfu,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] cmd_count
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_RESULT = 3'd4;

  localparam int IW = $clog2(POLL_MAX + 1);
  localparam int GW = $clog2(POLL_GAP + 1);

  logic [2:0]    state;
  logic          poll;
  logic [IW-1:0] issues;
  logic [GW-1:0] gap_cnt;

  assign req_ready     = (state == S_IDLE);
  assign cfu.rsp_ready = (state == S_WAIT);
  assign busy          = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state                       <= S_IDLE;
      cfu.cmd_valid               <= 1'b0;
      cfu.cmd_payload_function_id <= '0;
      cfu.cmd_payload_inputs_0    <= '0;
      cfu.cmd_payload_inputs_1    <= '0;
      res_valid                   <= 1'b0;
      res_timeout                 <= 1'b0;
      res_data                    <= '0;
      cmd_count                   <= '0;
      poll                        <= 1'b0;
      issues                      <= '0;
      gap_cnt                     <= '0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          cfu.cmd_payload_function_id <= req_function_id;
          cfu.cmd_payload_inputs_0    <= req_inputs_0;
          cfu.cmd_payload_inputs_1    <= req_inputs_1;
          poll                        <= req_poll;
          issues                      <= '0;
          res_timeout                 <= 1'b0;
          cfu.cmd_valid               <= 1'b1;
          state                       <= S_ISSUE;
        end
        S_ISSUE: if (cfu.cmd_ready) begin
          cfu.cmd_valid <= 1'b0;
          cmd_count     <= cmd_count + CNT_WIDTH'(1);
          issues        <= issues + IW'(1);
          state         <= S_WAIT;
        end
        // Responder pulses rsp_valid once and cannot be stalled, so capture unconditionally.
        S_WAIT: if (cfu.rsp_valid) begin
          res_data <= cfu.rsp_payload_outputs_0;
          if (!poll || cfu.rsp_payload_outputs_0 != 32'd0) begin
            res_valid <= 1'b1;
            state     <= S_RESULT;
          end else if (issues == IW'(POLL_MAX)) begin
            res_valid   <= 1'b1;
            res_timeout <= 1'b1;
            state       <= S_RESULT;
          end else begin
            gap_cnt <= '0;
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt == GW'(POLL_GAP - 1)) begin
            cfu.cmd_valid <= 1'b1;
            state         <= S_ISSUE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        S_RESULT: if (res_ready) begin
          res_valid <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cfu_cmd_master.sv
// Randomized bench for cfu_cmd_master with a transaction-level model and a CFU responder model.
module tb_cfu_cmd_master;
  localparam int POLL_GAP = 4;
  localparam int POLL_MAX = 3;
  localparam int CW       = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          req_valid, req_ready, req_poll;
  logic [9:0]    req_function_id;
  logic [31:0]   req_inputs_0, req_inputs_1;
  logic          res_valid, res_ready, res_timeout;
  logic [31:0]   res_data;
  logic          busy;
  logic [CW-1:0] cmd_count;

  cfu_cmd_master_if bus();

  cfu_cmd_master #(.POLL_GAP(POLL_GAP), .POLL_MAX(POLL_MAX), .CNT_WIDTH(CW)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_function_id(req_function_id),
    .req_inputs_0(req_inputs_0), .req_inputs_1(req_inputs_1), .req_poll(req_poll),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_timeout(res_timeout),
    .cfu(bus), .busy(busy), .cmd_count(cmd_count)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Stimulus knobs shared with the responder and ready drivers
  int rnd = 0, rsp_lat = 2, zero_left = 0, plan_zeros = 0;
  int cr_lo = 0, rr_lo = 0;
  bit inject_rsp = 0;

  // CFU responder: returns in0+in1 after rsp_lat cycles, or 0 while zero_left > 0
  int          rsp_cd = 0;
  logic [31:0] rsp_val;
  always @(posedge clk) begin
    logic        hs, rst;
    logic [31:0] a, b;
    hs  = bus.cmd_valid && bus.cmd_ready;
    rst = !resetn;
    a   = bus.cmd_payload_inputs_0;
    b   = bus.cmd_payload_inputs_1;
    #1;
    bus.rsp_valid = 1'b0;
    if (rst) rsp_cd = 0;
    else begin
      if (rsp_cd > 0) begin
        rsp_cd--;
        if (rsp_cd == 0) begin bus.rsp_valid = 1'b1; bus.rsp_payload_outputs_0 = rsp_val; end
      end
      if (hs) begin
        rsp_val = (zero_left > 0) ? 32'd0 : a + b;
        if (zero_left > 0) zero_left--;
        if (rsp_lat == 1) begin bus.rsp_valid = 1'b1; bus.rsp_payload_outputs_0 = rsp_val; end
        else rsp_cd = rsp_lat - 1;
      end
      if (inject_rsp) begin
        bus.rsp_valid = 1'b1; bus.rsp_payload_outputs_0 = 32'hdead; inject_rsp = 0;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (cr_lo > 0) begin bus.cmd_ready = 1'b0; cr_lo--; end
    else bus.cmd_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (rr_lo > 0) begin res_ready = 1'b0; rr_lo--; end
    else res_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  // Transaction model and per-cycle compare
  logic [9:0]  cur_f;
  logic [31:0] cur_a, cur_b, exp_data, last_data = 0, done_data = 0;
  logic        cur_poll = 0, exp_to = 0, done_to = 0;
  int cur_zeros, exp_issues = 0, issues_seen = 0, done_issues = 0, hs_total = 0;
  int ncyc = 0, last_zero = -1, gap_checks = 0, stall_cnt = 0, hold_cnt = 0;
  int t_req = 0, t_cmd1 = -1, t_res1 = -1;
  bit rst_prev = 1, prev_req_hs = 0, prev_stall = 0, prev_hold = 0, prev_res_hs = 0;
  bit prev_cv = 0, waiting = 0;

  always @(negedge clk) begin
    ncyc++;
    if (rst_prev) begin
      check("rst_busy", busy, 0);
      check("rst_cmd_valid", bus.cmd_valid, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_timeout", res_timeout, 0);
      check("rst_cmd_count", cmd_count, 0);
      check("rst_res_data", res_data, 0);
    end else begin
      check("req_ready", req_ready, !busy);
      if (prev_req_hs) check("issue_after_req", {busy, bus.cmd_valid}, 2'b11);
      if (prev_stall) check("cmd_valid_held", bus.cmd_valid, 1);
      if (bus.cmd_valid) begin
        check("cmd_fid", bus.cmd_payload_function_id, cur_f);
        check("cmd_in0", bus.cmd_payload_inputs_0, cur_a);
        check("cmd_in1", bus.cmd_payload_inputs_1, cur_b);
        check("no_cmd_in_result", res_valid, 0);
      end
      if (res_valid) begin
        check("res_data", res_data, exp_data);
        check("res_timeout", res_timeout, exp_to);
        check("issue_count", issues_seen, exp_issues);
      end
      if (prev_hold) check("res_valid_held", res_valid, 1);
      if (prev_res_hs) check("idle_after_result", {busy, res_valid}, 0);
      if (!busy) check("res_data_idle", res_data, last_data);
      check("cmd_count", cmd_count, hs_total[CW-1:0]);
      if (bus.cmd_valid && !prev_cv && last_zero >= 0) begin
        check("poll_gap", ncyc - last_zero, POLL_GAP + 1);
        gap_checks++;
        last_zero = -1;
      end
    end
    prev_req_hs = 0; prev_stall = 0; prev_hold = 0; prev_res_hs = 0;
    prev_cv = bus.cmd_valid;
    if (!resetn) begin
      rst_prev = 1; hs_total = 0; last_data = 0; waiting = 0; last_zero = -1;
    end else begin
      rst_prev = 0;
      if (req_valid && req_ready) begin
        cur_f = req_function_id; cur_a = req_inputs_0; cur_b = req_inputs_1;
        cur_poll = req_poll; cur_zeros = plan_zeros;
        if (!cur_poll) begin
          exp_issues = 1; exp_to = 0; exp_data = (cur_zeros > 0) ? 32'd0 : cur_a + cur_b;
        end else if (cur_zeros >= POLL_MAX) begin
          exp_issues = POLL_MAX; exp_to = 1; exp_data = 32'd0;
        end else begin
          exp_issues = cur_zeros + 1; exp_to = 0; exp_data = cur_a + cur_b;
        end
        issues_seen = 0; t_req = ncyc; t_cmd1 = -1; t_res1 = -1; prev_req_hs = 1;
      end
      if (bus.cmd_valid) begin
        if (bus.cmd_ready) begin
          hs_total++; issues_seen++; waiting = 1;
          if (t_cmd1 < 0) t_cmd1 = ncyc;
        end else begin
          stall_cnt++; prev_stall = 1;
        end
      end
      if (bus.rsp_valid && waiting) begin
        waiting = 0;
        if (bus.rsp_payload_outputs_0 == 0 && cur_poll && issues_seen < POLL_MAX) last_zero = ncyc;
      end
      if (res_valid) begin
        if (t_res1 < 0) t_res1 = ncyc;
        last_zero = -1;
        if (res_ready) begin
          prev_res_hs = 1; last_data = exp_data;
          done_data = res_data; done_to = res_timeout; done_issues = issues_seen;
        end else begin
          hold_cnt++; prev_hold = 1;
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin @(posedge clk); #1; n++; end
    if (busy) check("wait_idle_timeout", 1, 0);
  endtask

  task automatic send(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic p, input int z, input int crlo);
    wait_idle();
    zero_left = z; plan_zeros = z; cr_lo = crlo;
    req_function_id = f; req_inputs_0 = a; req_inputs_1 = b; req_poll = p; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, n;
    resetn = 1'b0; req_valid = 1'b0; req_poll = 1'b0; req_function_id = '0;
    req_inputs_0 = '0; req_inputs_1 = '0; res_ready = 1'b1;
    bus.cmd_ready = 1'b1; bus.rsp_valid = 1'b0; bus.rsp_payload_outputs_0 = '0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // Plain command, 2-cycle responder
    send({7'd0, 3'd0}, 32'd5, 32'd7, 1'b0, 0, 0);
    wait_idle();
    check("t1_data", done_data, 12);
    check("t1_timeout", done_to, 0);
    check("t1_count", cmd_count, 1);
    check("t1_cmd_lat", t_cmd1 - t_req, 1);
    check("t1_res_lat", t_res1 - t_req, 4);

    // Poll returns 0,0,1
    s0 = gap_checks;
    send({7'd1, 3'd7}, 32'd1, 32'd0, 1'b1, 2, 0);
    wait_idle();
    check("t2_issues", done_issues, 3);
    check("t2_data", done_data, 1);
    check("t2_gaps", gap_checks - s0, 2);

    // Poll never succeeds
    send({7'd1, 3'd7}, 32'd3, 32'd4, 1'b1, 10, 0);
    wait_idle();
    check("t3_issues", done_issues, 3);
    check("t3_timeout", done_to, 1);
    check("t3_data", done_data, 0);

    // cmd_ready low for the first 5 cycles of the issue
    s0 = stall_cnt;
    send({7'd2, 3'd1}, 32'd9, 32'd3, 1'b0, 0, 6);
    wait_idle();
    check("t4_stalls", stall_cnt - s0, 5);
    check("t4_issues", done_issues, 1);
    check("t4_data", done_data, 12);

    // res_ready low 10 cycles
    s0 = hold_cnt;
    send({7'd3, 3'd2}, 32'd100, 32'd23, 1'b0, 0, 0);
    n = 0;
    while (!res_valid && n < 100) begin @(posedge clk); #1; n++; end
    rr_lo = 10;
    wait_idle();
    check("t5_holds", hold_cnt - s0, 10);
    check("t5_data", done_data, 123);

    // Reset while waiting for the response, then a stray response
    rsp_lat = 5;
    send({7'd0, 3'd0}, 32'd1, 32'd2, 1'b0, 0, 0);
    n = 0;
    while (bus.cmd_valid && n < 100) begin @(posedge clk); #1; n++; end
    check("t6_in_wait", {busy, bus.cmd_valid}, 2'b10);
    resetn = 1'b0;
    @(posedge clk); #1;
    check("t6_busy", busy, 0);
    check("t6_cmd_valid", bus.cmd_valid, 0);
    check("t6_res_valid", res_valid, 0);
    check("t6_count", cmd_count, 0);
    resetn = 1'b1; inject_rsp = 1;
    repeat (4) @(posedge clk);
    #1;
    check("t6_stray_busy", busy, 0);
    check("t6_stray_data", res_data, 0);
    check("t6_stray_res", res_valid, 0);

    // Randomized traffic with random backpressure and latency
    rnd = 1;
    for (int i = 0; i < 300; i++) begin
      logic        p;
      logic [31:0] a, b;
      p = 1'($urandom_range(0, 1));
      a = $urandom; b = $urandom;
      if (p) begin a[0] = 1'b1; b[0] = 1'b0; end
      rsp_lat = $urandom_range(1, 4);
      send(10'($urandom), a, b, p, $urandom_range(0, 4), 0);
    end
    wait_idle();
    rnd = 0;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
